// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit engine.
package uart_pkg;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_t;

  localparam logic [1:0] DATA_BITS_5 = 2'b00;
  localparam logic [1:0] DATA_BITS_6 = 2'b01;
  localparam logic [1:0] DATA_BITS_7 = 2'b10;
  localparam logic [1:0] DATA_BITS_8 = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  // Unused parity codes fall back to no parity.
  function automatic parity_t decode_parity(logic [2:0] code);
    case (code)
      3'b001:  return PAR_EVEN;
      3'b010:  return PAR_ODD;
      3'b011:  return PAR_MARK;
      3'b100:  return PAR_SPACE;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic logic [7:0] data_mask(logic [1:0] bits);
    return 8'hff >> (3'd3 - {1'b0, bits});
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Write-side push handshake between the register block and the TX engine.
interface uart_tx_engine_if;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered count/empty/full; head word read straight from storage.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, full_q;
  logic             do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: write FIFO feeding a run-time configurable frame serialiser.
// Optional clear-to-send gating is enabled with the UART_TX_CTS_EN macro.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_engine_if.slave      wr,
  input  logic [1:0]           cfg_data_bits,
  input  logic [2:0]           cfg_parity,
  input  logic                 cfg_stop2,
  input  logic [DIV_WIDTH-1:0] cfg_baud_div,
  input  logic                 tx_enable,
`ifdef UART_TX_CTS_EN
  input  logic                 cts_n,
`endif
  output logic                 txd,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] fifo_count,
  output logic                 fifo_empty,
  output logic                 fifo_full
);

  logic [7:0] head;
  logic       pop;
  logic       clear_to_send;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr.wr_valid),
    .push_data (wr.wr_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign wr.wr_ready = ~fifo_full;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cts_sync_q <= 2'b11;
    else     cts_sync_q <= {cts_sync_q[0], cts_n};
  end

  assign clear_to_send = ~cts_sync_q[1];
`else
  assign clear_to_send = 1'b1;
`endif

  tx_state_t            state_q;
  logic [DIV_WIDTH-1:0] baud_cnt_q;
  logic [2:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic                 busy_q, txd_q;
  logic [7:0]           shd_data_q;
  logic [2:0]           shd_last_q;
  logic                 shd_par_en_q, shd_par_bit_q, shd_stop2_q;
  logic [DIV_WIDTH-1:0] shd_div_q;

  logic       bit_done, stop_last, start_ok, frame_start, tx_bit;
  logic [7:0] new_data;
  logic       new_par_bit;
  parity_t    new_par;

  assign bit_done  = (baud_cnt_q == '0);
  assign stop_last = (stop_idx_q == shd_stop2_q);
  assign start_ok  = !fifo_empty && tx_enable && clear_to_send;
  // A new frame starts from idle or directly out of the final stop bit.
  assign frame_start = start_ok &&
                       ((state_q == StIdle) || (state_q == StStop && bit_done && stop_last));
  assign pop = frame_start;

  always_comb begin
    new_data = head & data_mask(cfg_data_bits);
    new_par  = decode_parity(cfg_parity);
    case (new_par)
      PAR_EVEN: new_par_bit = ^new_data;
      PAR_ODD:  new_par_bit = ~^new_data;
      PAR_MARK: new_par_bit = 1'b1;
      default:  new_par_bit = 1'b0;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    case (state_q)
      StStart:  tx_bit = 1'b0;
      StData:   tx_bit = shd_data_q[bit_idx_q];
      StParity: tx_bit = shd_par_bit_q;
      default:  tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      baud_cnt_q    <= '0;
      bit_idx_q     <= '0;
      stop_idx_q    <= 1'b0;
      busy_q        <= 1'b0;
      txd_q         <= 1'b1;
      shd_data_q    <= '0;
      shd_last_q    <= '0;
      shd_par_en_q  <= 1'b0;
      shd_par_bit_q <= 1'b0;
      shd_stop2_q   <= 1'b0;
      shd_div_q     <= '0;
    end else begin
      if (state_q != StIdle) baud_cnt_q <= bit_done ? shd_div_q : baud_cnt_q - DIV_WIDTH'(1);

      unique case (state_q)
        StIdle: ;
        StStart: begin
          if (bit_done) begin
            state_q   <= StData;
            bit_idx_q <= '0;
          end
        end
        StData: begin
          if (bit_done) begin
            if (bit_idx_q == shd_last_q) state_q <= shd_par_en_q ? StParity : StStop;
            else                         bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        StParity: begin
          if (bit_done) state_q <= StStop;
        end
        StStop: begin
          if (bit_done) begin
            if (!stop_last) begin
              stop_idx_q <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // Shadow config so mid-frame changes only affect the next frame.
      if (frame_start) begin
        state_q       <= StStart;
        busy_q        <= 1'b1;
        baud_cnt_q    <= cfg_baud_div;
        stop_idx_q    <= 1'b0;
        shd_data_q    <= new_data;
        shd_last_q    <= {1'b0, cfg_data_bits} + 3'd4;
        shd_par_en_q  <= (new_par != PAR_NONE);
        shd_par_bit_q <= new_par_bit;
        shd_stop2_q   <= cfg_stop2;
        shd_div_q     <= cfg_baud_div;
      end

      txd_q <= tx_bit;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule
